gpr_wb_arbiter: RTL and testbench

Shares the single GPR write port between three write-back sources: the ALU result, load data and the UART receive byte. Each cycle it picks one requester by fixed priority with anti-starvation aging. It registers the chosen write onto the register-file port and reports completion with a one-cycle finish pulse tagged by source. It sits between the execute/load/UART units and the GPR array, replacing the per-source write paths.

---
 rtl/gpr_wb_arbiter_if.sv | 50 +++++
 rtl/gpr_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gpr_wb_arbiter_if.sv
// gpr_wb_arbiter_if
// Bundles the three write-back requester channels (ALU, LOAD, UART) and the
// GPR write / completion outputs shared between the arbiter and its users.
//   alu_*/load_*/uart_*  : req/addr/data from each source, gnt back to it
//   gpr_we/waddr/wdata   : registered register-file write port
//   wgpr_finish/wb_src   : one-cycle completion pulse tagged by source
// Modports:
//   master : requester / register-file side (drives req, addr, data)
//   slave  : arbiter side (drives gnt, gpr_*, finish)
interface gpr_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_req;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_gnt;

  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_gnt;

  logic              uart_req;
  logic [ADDR_W-1:0] uart_addr;
  logic [7:0]        uart_data;
  logic              uart_gnt;

  logic              gpr_we;
  logic [ADDR_W-1:0] gpr_waddr;
  logic [DATA_W-1:0] gpr_wdata;
  logic              wgpr_finish;
  logic [1:0]        wb_src;

  modport master (
    output alu_req, alu_addr, alu_data,
    output load_req, load_addr, load_data,
    output uart_req, uart_addr, uart_data,
    input  alu_gnt, load_gnt, uart_gnt,
    input  gpr_we, gpr_waddr, gpr_wdata, wgpr_finish, wb_src
  );

  modport slave (
    input  alu_req, alu_addr, alu_data,
    input  load_req, load_addr, load_data,
    input  uart_req, uart_addr, uart_data,
    output alu_gnt, load_gnt, uart_gnt,
    output gpr_we, gpr_waddr, gpr_wdata, wgpr_finish, wb_src
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
// Shares the single GPR write port between ALU, LOAD and UART write-back.
// One requester is granted per cycle (combinational gnt): urgent requesters
// first, then LOAD > ALU > UART. The winning write is registered onto the
// GPR port the next cycle and a finish pulse tagged with the source follows
// one cycle after that. Stages overlap, so back-to-back grants are allowed.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : gpr_wb_arbiter_if.slave (requests, grants, GPR port, finish)

// Per-requester aging counter. Counts denied cycles while the request is
// held, saturates at LIMIT, clears on grant or when the request drops.
module gpr_wb_age #(
  parameter int LIMIT = 4,
  parameter int CW    = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic req,
  input  logic gnt,
  output logic urgent
);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             cnt <= '0;
    else if (!req || gnt)  cnt <= '0;
    else if (cnt != LIM)   cnt <= cnt + 1'b1;
  end

  assign urgent = (cnt == LIM);
endmodule

module gpr_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5
) (
  input  logic               clk,
  input  logic               rstn,
  gpr_wb_arbiter_if.slave    bus
);
  localparam int NUM_LANES = 3;
  localparam int STAGES    = 2;   // issue stage, finish stage
  localparam int CW        = $clog2(STARVE_LIMIT + 1);

  // lane index doubles as the wb_src encoding
  localparam int L_ALU  = 0;
  localparam int L_LOAD = 1;
  localparam int L_UART = 2;

  logic [NUM_LANES-1:0]             req, urg, cand, gnt_sel, gnt;
  logic [NUM_LANES-1:0][ADDR_W-1:0] addr;
  logic [NUM_LANES-1:0][DATA_W-1:0] data;

  logic              any_gnt;
  logic [1:0]        sel_src;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic [STAGES:1]       vld_pipe;
  logic [STAGES:1][1:0]  src_pipe;
  logic                  we_q;
  logic [ADDR_W-1:0]     waddr_q;
  logic [DATA_W-1:0]     wdata_q;

  assign req = {bus.uart_req, bus.load_req, bus.alu_req};

  always_comb begin
    addr         = '0;
    data         = '0;
    addr[L_ALU]  = bus.alu_addr;
    addr[L_LOAD] = bus.load_addr;
    addr[L_UART] = bus.uart_addr;
    data[L_ALU]  = bus.alu_data;
    data[L_LOAD] = bus.load_data;
    data[L_UART] = {{(DATA_W-8){1'b0}}, bus.uart_data};
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    gpr_wb_age #(.LIMIT(STARVE_LIMIT), .CW(CW)) u_age (
      .clk    (clk),
      .rstn   (rstn),
      .req    (req[i]),
      .gnt    (gnt[i]),
      .urgent (urg[i])
    );
  end

  // Urgent requesters form the candidate set whenever any exist; the fixed
  // LOAD > ALU > UART order then resolves within that set.
  always_comb begin
    cand    = (|(req & urg)) ? (req & urg) : req;
    gnt_sel = '0;
    if (cand[L_LOAD])      gnt_sel[L_LOAD] = 1'b1;
    else if (cand[L_ALU])  gnt_sel[L_ALU]  = 1'b1;
    else if (cand[L_UART]) gnt_sel[L_UART] = 1'b1;
  end

  // Grants are suppressed while reset is asserted.
  assign gnt     = rstn ? gnt_sel : '0;
  assign any_gnt = |gnt;

  always_comb begin
    sel_src  = 2'(L_ALU);
    sel_addr = addr[L_ALU];
    sel_data = data[L_ALU];
    if (gnt[L_LOAD]) begin
      sel_src  = 2'(L_LOAD);
      sel_addr = addr[L_LOAD];
      sel_data = data[L_LOAD];
    end else if (gnt[L_UART]) begin
      sel_src  = 2'(L_UART);
      sel_addr = addr[L_UART];
      sel_data = data[L_UART];
    end
  end

  assign bus.alu_gnt  = gnt[L_ALU];
  assign bus.load_gnt = gnt[L_LOAD];
  assign bus.uart_gnt = gnt[L_UART];

  // Issue/finish pipeline. r0 writes still flow through as a grant and a
  // finish pulse, but never assert the register-file write enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      src_pipe <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], any_gnt};
      src_pipe <= {src_pipe[STAGES-1:1], sel_src};
      we_q     <= any_gnt && (sel_addr != '0);
      if (any_gnt) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  assign bus.gpr_we      = we_q;
  assign bus.gpr_waddr   = waddr_q;
  assign bus.gpr_wdata   = wdata_q;
  assign bus.wgpr_finish = vld_pipe[STAGES];
  assign bus.wb_src      = src_pipe[STAGES];
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;
  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gpr_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  gpr_wb_arbiter #(.STARVE_LIMIT(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  src;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t q_gnt[$];
  ent_t q_we[$];
  ent_t q_fin[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // expected grant now, GPR write next cycle (unless r0), finish after that
  task automatic exp_grant(input logic [1:0] src, input logic [4:0] a, input logic [31:0] d);
    ent_t e;
    e.cyc = cyc; e.src = src; e.addr = a; e.data = d;
    q_gnt.push_back(e);
    if (a != 5'd0) begin
      e.cyc = cyc + 1;
      q_we.push_back(e);
    end
    e.cyc = cyc + 2;
    q_fin.push_back(e);
  endtask

  task automatic exp_gnt_only(input logic [1:0] src);
    ent_t e;
    e.cyc = cyc; e.src = src; e.addr = '0; e.data = '0;
    q_gnt.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented grant / write / finish against the
  // front of its queue, and flags anything due but not presented.
  always @(negedge clk) begin
    logic [2:0] g;
    ent_t e;
    g = {bus.uart_gnt, bus.load_gnt, bus.alu_gnt};
    if (g != 3'b000) begin
      if (q_gnt.size() == 0 || q_gnt[0].cyc != cyc) begin
        total++; bad++;
        $display("FAIL gnt_unexpected cyc=%0d got=%b", cyc, g);
      end else begin
        e = q_gnt.pop_front();
        chk("gnt_vec", {29'd0, g}, {29'd0, 3'b001 << e.src});
      end
    end else if (q_gnt.size() > 0 && q_gnt[0].cyc <= cyc) begin
      e = q_gnt.pop_front();
      total++; bad++;
      $display("FAIL gnt_missing cyc=%0d got=000 exp_src=%0d", cyc, e.src);
    end

    if (bus.gpr_we) begin
      if (q_we.size() == 0 || q_we[0].cyc != cyc) begin
        total++; bad++;
        $display("FAIL we_unexpected cyc=%0d got_addr=%0d", cyc, bus.gpr_waddr);
      end else begin
        e = q_we.pop_front();
        chk("gpr_waddr", {27'd0, bus.gpr_waddr}, {27'd0, e.addr});
        chk("gpr_wdata", bus.gpr_wdata, e.data);
      end
    end else if (q_we.size() > 0 && q_we[0].cyc <= cyc) begin
      e = q_we.pop_front();
      total++; bad++;
      $display("FAIL we_missing cyc=%0d got=0 exp_addr=%0d", cyc, e.addr);
    end

    if (bus.wgpr_finish) begin
      if (q_fin.size() == 0 || q_fin[0].cyc != cyc) begin
        total++; bad++;
        $display("FAIL fin_unexpected cyc=%0d got_src=%0d", cyc, bus.wb_src);
      end else begin
        e = q_fin.pop_front();
        chk("wb_src", {30'd0, bus.wb_src}, {30'd0, e.src});
      end
    end else if (q_fin.size() > 0 && q_fin[0].cyc <= cyc) begin
      e = q_fin.pop_front();
      total++; bad++;
      $display("FAIL fin_missing cyc=%0d got=0 exp_src=%0d", cyc, e.src);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    bus.alu_req = 1'b1;  bus.alu_addr = 5'd1;  bus.alu_data = 32'h1;
    bus.load_req = 1'b0; bus.load_addr = '0;   bus.load_data = '0;
    bus.uart_req = 1'b0; bus.uart_addr = '0;   bus.uart_data = '0;
    #2;
    // reset state; a raised request must not be granted during reset
    chk("rst_gpr_we",    {31'd0, bus.gpr_we}, 32'd0);
    chk("rst_gpr_waddr", {27'd0, bus.gpr_waddr}, 32'd0);
    chk("rst_gpr_wdata", bus.gpr_wdata, 32'd0);
    chk("rst_finish",    {31'd0, bus.wgpr_finish}, 32'd0);
    chk("rst_wb_src",    {30'd0, bus.wb_src}, 32'd0);
    chk("rst_alu_gnt",   {31'd0, bus.alu_gnt}, 32'd0);
    bus.alu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step();

    // 1: single ALU write
    bus.alu_req = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'hDEADBEEF;
    exp_grant(2'd0, 5'd3, 32'hDEADBEEF);
    step();
    bus.alu_req = 1'b0;
    repeat (3) step();

    // 2: all three at once, fixed priority LOAD > ALU > UART
    bus.load_req = 1'b1; bus.load_addr = 5'd5; bus.load_data = 32'h11;
    bus.alu_req  = 1'b1; bus.alu_addr  = 5'd6; bus.alu_data  = 32'h22;
    bus.uart_req = 1'b1; bus.uart_addr = 5'd7; bus.uart_data = 8'h41;
    exp_grant(2'd1, 5'd5, 32'h11);
    step();
    bus.load_req = 1'b0;
    exp_grant(2'd0, 5'd6, 32'h22);
    step();
    bus.alu_req = 1'b0;
    exp_grant(2'd2, 5'd7, 32'h41);
    step();
    bus.uart_req = 1'b0;
    repeat (3) step();

    // 3: LOAD hogs, UART ages to urgent after 4 denied cycles
    bus.uart_req = 1'b1; bus.uart_addr = 5'd20; bus.uart_data = 8'h7E;
    for (int i = 0; i < 4; i++) begin
      bus.load_req = 1'b1; bus.load_addr = 5'(11 + i); bus.load_data = 32'hA0 + i;
      exp_grant(2'd1, 5'(11 + i), 32'hA0 + i);
      step();
    end
    bus.load_addr = 5'd15; bus.load_data = 32'hA4;
    exp_grant(2'd2, 5'd20, 32'h7E);
    step();
    bus.uart_req = 1'b0;
    exp_grant(2'd1, 5'd15, 32'hA4);
    step();
    bus.load_req = 1'b0;
    repeat (3) step();

    // 4: write to r0: grant and finish, no write enable, port still updates
    bus.alu_req = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'h12345678;
    exp_grant(2'd0, 5'd0, 32'h12345678);
    step();
    bus.alu_req = 1'b0;
    chk("r0_waddr", {27'd0, bus.gpr_waddr}, 32'd0);
    chk("r0_wdata", bus.gpr_wdata, 32'h12345678);
    repeat (3) step();

    // 6: UART byte is zero-extended
    bus.uart_req = 1'b1; bus.uart_addr = 5'd9; bus.uart_data = 8'hFF;
    exp_grant(2'd2, 5'd9, 32'h000000FF);
    step();
    bus.uart_req = 1'b0;
    repeat (3) step();

    // 5: reset in the issue cycle discards the pending write and finish
    bus.uart_req = 1'b1; bus.uart_addr = 5'd4; bus.uart_data = 8'h33;
    exp_gnt_only(2'd2);
    step();
    bus.uart_req = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("midrst_gpr_we", {31'd0, bus.gpr_we}, 32'd0);
    chk("midrst_finish", {31'd0, bus.wgpr_finish}, 32'd0);
    rstn = 1'b1;
    repeat (3) step();
    bus.alu_req = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'hCAFEF00D;
    exp_grant(2'd0, 5'd3, 32'hCAFEF00D);
    step();
    bus.alu_req = 1'b0;
    repeat (4) step();

    chk("leftover_gnt", q_gnt.size(), 32'd0);
    chk("leftover_we",  q_we.size(),  32'd0);
    chk("leftover_fin", q_fin.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
